// File: rtl/disp_pkg.sv
// Shared display definitions for the digit scanner and the downstream anode decoder.
// Also holds the leading-zero suppression rule so every consumer applies it the same way.
package disp_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam int BCD_W       = 4;
  localparam int SEL_W       = 2;

  typedef logic [DIGIT_COUNT-1:0][BCD_W-1:0] bcd_digits_t;

  // A digit is blanked only when it and every more-significant digit are zero.
  // Digit 0 is always shown, so a value of zero still displays "0".
  function automatic logic [DIGIT_COUNT-1:0] lz_suppress(input bcd_digits_t d,
                                                         input logic        lz_en);
    logic [DIGIT_COUNT-1:0] sup;
    sup = '0;
    if (lz_en) begin
      sup[DIGIT_COUNT-1] = (d[DIGIT_COUNT-1] == '0);
      for (int i = DIGIT_COUNT-2; i >= 1; i--) begin
        sup[i] = sup[i+1] & (d[i] == '0);
      end
    end
    return sup;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/digit counter for the display scanner.
// Produces the active digit index, the run flag, and the frame-wrap strobe and pulse.
module scan_timer
  import disp_pkg::*;
#(
  parameter  int TICKS_PER_DIGIT = 100000,
  localparam int CNT_W           = $clog2(TICKS_PER_DIGIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             run_o,
  output logic             frame_start_o,
  output logic             frame_wrap_o
);

  localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(DIGIT_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             run_q;
  logic             frame_start_q;
  logic             slot_wrap;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    slot_wrap    = en & (cnt_q == LAST_TICK);
    frame_wrap_o = slot_wrap & (sel_q == LAST_DIGIT);
    if (en) begin
      if (slot_wrap) begin
        cnt_d = '0;
        sel_d = sel_q + SEL_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      sel_q         <= '0;
      run_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      run_q         <= en;
      frame_start_q <= frame_wrap_o;
    end
  end

  assign cnt_o         = cnt_q;
  assign sel_o         = sel_q;
  assign run_o         = run_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/digit_scanner.sv
// Four-digit multiplexed display scanner with blanking, leading-zero suppression
// and a per-frame snapshot so a digit never tears mid-frame.
module digit_scanner
  import disp_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [15:0]            digits_in,
  input  logic [DIGIT_COUNT-1:0] dp_in,
  input  logic                   lz_en,
  output logic [SEL_W-1:0]       digit_sel,
  output logic [BCD_W-1:0]       digit_val,
  output logic                   dp_out,
  output logic                   digit_on,
  output logic                   frame_start
);

  localparam int CNT_W = $clog2(TICKS_PER_DIGIT);

  logic [CNT_W-1:0]       cnt;
  logic [SEL_W-1:0]       sel;
  logic                   run;
  logic                   frame_wrap;
  bcd_digits_t            snap_digits_q, snap_digits_d;
  logic [DIGIT_COUNT-1:0] snap_dp_q, snap_dp_d;
  logic [DIGIT_COUNT-1:0] sup;

  scan_timer #(
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cnt_o         (cnt),
    .sel_o         (sel),
    .run_o         (run),
    .frame_start_o (frame_start),
    .frame_wrap_o  (frame_wrap)
  );

  // Track live inputs while idle so a fresh enable shows current data;
  // once running, only a frame boundary may replace the displayed value.
  always_comb begin
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    if (!run || frame_wrap) begin
      snap_digits_d = digits_in;
      snap_dp_d     = dp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
    end else begin
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
    end
  end

  always_comb begin
    sup       = lz_suppress(snap_digits_q, lz_en);
    digit_sel = sel;
    digit_val = snap_digits_q[sel];
    dp_out    = snap_dp_q[sel];
    digit_on  = run & (cnt >= CNT_W'(BLANK_TICKS)) & ~sup[sel];
  end

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner: a position-based reference model predicts each
// cycle's outputs, and an independent monitor compares them against the DUT.
module tb_digit_scanner;

  localparam int T     = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * T;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_val;
  logic        dp_out;
  logic        digit_on;
  logic        frame_start;

  digit_scanner #(
    .TICKS_PER_DIGIT(T),
    .BLANK_TICKS    (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .lz_en       (lz_en),
    .digit_sel   (digit_sel),
    .digit_val   (digit_val),
    .dp_out      (dp_out),
    .digit_on    (digit_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] val;
    logic       dp;
    logic       on_base;
    logic       sup_if_lz;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;

  // Reference model state: enabled edges since reset, displayed value, run flag.
  int          steps = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;
  logic        m_run = 1'b0;
  logic        m_fs  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   p;
    bit   boundary;
    bit   zeros_above;
    if (rst) begin
      steps = 0;
      m_dig = '0;
      m_dp  = '0;
      m_run = 1'b0;
      m_fs  = 1'b0;
    end else begin
      boundary = en && ((steps % FRAME) == FRAME - 1);
      if (!m_run || boundary) begin
        m_dig = digits_in;
        m_dp  = dp_in;
      end
      if (en) steps++;
      m_run = en;
      m_fs  = boundary;
    end
    p           = steps % FRAME;
    e.sel       = 2'(p / T);
    e.val       = m_dig[(p / T) * 4 +: 4];
    e.dp        = m_dp[p / T];
    e.on_base   = m_run && ((p % T) >= BLANK);
    zeros_above = 1'b1;
    for (int i = p / T; i < 4; i++) begin
      if (m_dig[i * 4 +: 4] != 4'd0) zeros_above = 1'b0;
    end
    e.sup_if_lz = (p / T != 0) && zeros_above;
    e.fs        = m_fs;
    sb_q.push_back(e);
    started = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("digit_sel",   32'(digit_sel),   32'(e.sel));
        check("digit_val",   32'(digit_val),   32'(e.val));
        check("dp_out",      32'(dp_out),      32'(e.dp));
        check("digit_on",    32'(digit_on),    32'(e.on_base && !(lz_en && e.sup_if_lz)));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (((steps % FRAME) != target) && (k < 200)) begin
      cycles(1);
      k++;
    end
    check("wait_position", 32'(steps % FRAME), 32'(target));
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      d[i * 4 +: 4] = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    end
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    lz_en     = 1'b0;
    cycles(3);
    rst = 1'b0;
    en  = 1'b1;
    cycles(2 * FRAME + 3);

    wait_pos(T);
    digits_in = 16'h5678;
    cycles(FRAME + 10);

    lz_en     = 1'b1;
    digits_in = 16'h0070;
    cycles(2 * FRAME + 4);

    digits_in = 16'h0000;
    dp_in     = 4'b1000;
    cycles(2 * FRAME + 4);

    lz_en     = 1'b0;
    digits_in = 16'h9A0C;
    dp_in     = 4'b0101;
    wait_pos(2 * T + 4);
    en = 1'b0;
    cycles(5);
    en = 1'b1;
    cycles(FRAME + 6);

    wait_pos(FRAME - 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(FRAME + 4);

    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(9, 0) != 0);
      if ($urandom_range(7, 0) == 0) digits_in = rand_digits();
      if ($urandom_range(7, 0) == 0) dp_in = 4'($urandom_range(15, 0));
      if ($urandom_range(63, 0) == 0) lz_en = ~lz_en;
      rst = ($urandom_range(199, 0) == 0);
      cycles(1);
    end
    rst = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
